// File: rtl/fsm_estrutural_core_pkg.sv
// Purpose : shared state encoding and lamp decode for the traffic-light controller.
// Latency : n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package fsm_estrutural_core_pkg;

    // Two-bit state register encoding. 2'b11 is unreachable in normal
    // operation; it decodes to all lamps off and falls back to GREEN.
    typedef enum logic [1:0] {
        ST_GREEN   = 2'b00,
        ST_YELLOW  = 2'b01,
        ST_RED     = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_e;

    // Lamp bundle, ordered {red, ylw, grn} so it reads left to right like
    // the output port list.
    typedef struct packed {
        logic red;
        logic ylw;
        logic grn;
    } lamps_t;

    // Moore output decode. Each lamp is a full two-bit match so the illegal
    // code lights nothing and at most one lamp can ever be on.
    function automatic lamps_t decode_lamps(input logic [1:0] s);
        lamps_t l;
        l.grn = (s == ST_GREEN);
        l.ylw = (s == ST_YELLOW);
        l.red = (s == ST_RED);
        return l;
    endfunction

endpackage

// File: rtl/dff_ar_n.sv
// Purpose : single D flip-flop with asynchronous active-low clear.
// Latency : q follows d one clk rising edge later; clear is immediate.
// Backpressure: none.
//
// Ports:
//   d     - data input, captured on rising clk
//   clk   - clock
//   rst_n - asynchronous active-low clear, forces q=0 without a clock edge
//   q     - registered output
module dff_ar_n (
    input  logic d,
    input  logic clk,
    input  logic rst_n,
    output logic q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/fsm_estrutural_core.sv
// Purpose : structural Moore traffic-light controller (GREEN -> YELLOW -> RED -> GREEN).
// Latency : CAR in GREEN -> ylw after 1 edge, red after 2; timeout in RED -> grn after 1 edge.
// Backpressure: none; CAR and timeout are sampled only on the rising Clock edge, never latched.
//
// Ports:
//   Clock   - system clock, rising edge
//   Reset   - asynchronous active-low reset, forces GREEN immediately
//   CAR     - car-present sensor
//   timeout - external timer expiry
//   red/ylw/grn - lamp drivers, active high, one-hot or all-off
module fsm_estrutural_core
    import fsm_estrutural_core_pkg::*;
(
    input  logic Clock,
    input  logic Reset,
    input  logic CAR,
    input  logic timeout,
    output logic red,
    output logic ylw,
    output logic grn
);

    // s_q[1:0] is the state register, s_d its next-state value.
    logic [1:0] s_q;
    logic [1:0] s_d;
    lamps_t     lamps;

    // Next-state equations, kept as plain gate expressions so the state
    // machine maps one-to-one onto two flops and a handful of gates.
    //   GREEN  : CAR moves to YELLOW, timeout has no effect.
    //   YELLOW : always RED next.
    //   RED    : hold until timeout, then GREEN; CAR has no effect.
    //   2'b11  : both terms are zero, so it drops to GREEN on the next edge.
    assign s_d[0] = ~s_q[1] & ~s_q[0] & CAR;
    assign s_d[1] = (~s_q[1] & s_q[0]) | (s_q[1] & ~s_q[0] & ~timeout);

    dff_ar_n u_s0 (
        .d     (s_d[0]),
        .clk   (Clock),
        .rst_n (Reset),
        .q     (s_q[0])
    );

    dff_ar_n u_s1 (
        .d     (s_d[1]),
        .clk   (Clock),
        .rst_n (Reset),
        .q     (s_q[1])
    );

    // Outputs depend on the registered state only, so sensor glitches
    // never reach the lamps.
    assign lamps = decode_lamps(s_q);
    assign red   = lamps.red;
    assign ylw   = lamps.ylw;
    assign grn   = lamps.grn;

endmodule

// File: tb/tb_fsm_estrutural_core.sv
module tb_fsm_estrutural_core;

    logic Clock;
    logic Reset;
    logic CAR;
    logic timeout;
    logic red;
    logic ylw;
    logic grn;

    int n_vectors;
    int n_miscompares;
    bit onehot_en;

    // Expected lamps {red, ylw, grn}, pushed when stimulus is applied,
    // popped when the output is sampled.
    logic [2:0] sb_q[$];

    localparam logic [2:0] L_GRN = 3'b001;
    localparam logic [2:0] L_YLW = 3'b010;
    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_OFF = 3'b000;

    fsm_estrutural_core dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .CAR     (CAR),
        .timeout (timeout),
        .red     (red),
        .ylw     (ylw),
        .grn     (grn)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Lamp exclusivity, checked away from the active edge on every cycle.
    always @(negedge Clock) begin
        if (onehot_en) begin
            n_vectors++;
            if ((int'(red) + int'(ylw) + int'(grn)) > 1) begin
                $display("FAIL onehot t=%0t got red=%b ylw=%b grn=%b want at most one lamp", $time, red, ylw, grn);
                n_miscompares++;
            end
        end
    end

    // Watchdog: the run is a fixed number of cycles, so this only fires on a hang.
    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish got t=%0t want < 200000", $time);
        $fatal(1, "watchdog");
    end

    // Drive inputs mid-period, record the lamps expected after the next
    // rising edge, then settle just past that edge.
    task automatic drive_cycle(input logic car, input logic to, input logic [2:0] exp);
        @(negedge Clock);
        CAR     = car;
        timeout = to;
        sb_q.push_back(exp);
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        logic [2:0] exp;
        logic [2:0] got;
        Reset   = 1'b0;
        CAR     = 1'b0;
        timeout = 1'b0;
        repeat (2) @(negedge Clock);
        // Still in reset, clock running for 20 ns.
        sb_q.push_back(L_GRN);
        exp = sb_q.pop_front();
        got = {red, ylw, grn};
        n_vectors++;
        if (got !== exp) begin
            $display("FAIL reset_hold got %b want %b", got, exp);
            n_miscompares++;
        end
        n_vectors++;
        if ({dut.u_s1.q, dut.u_s0.q} !== 2'b00) begin
            $display("FAIL reset_state got %b want 00", {dut.u_s1.q, dut.u_s0.q});
            n_miscompares++;
        end
        Reset = 1'b1;
        onehot_en = 1'b1;
        sb_q.push_back(L_GRN);
        @(posedge Clock);
        #1;
        exp = sb_q.pop_front();
        got = {red, ylw, grn};
        n_vectors++;
        if (got !== exp) begin
            $display("FAIL reset_release got %b want %b", got, exp);
            n_miscompares++;
        end
    endtask

    task automatic test_idle();
        logic [2:0] exp;
        logic [2:0] got;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 1'b1, L_GRN);
            exp = sb_q.pop_front();
            got = {red, ylw, grn};
            n_vectors++;
            if (got !== exp) begin
                $display("FAIL idle[%0d] got %b want %b", i, got, exp);
                n_miscompares++;
            end
        end
    endtask

    task automatic test_car_sequence();
        // {CAR, timeout, expected lamps}
        logic [4:0] tbl [6];
        logic [2:0] exp;
        logic [2:0] got;
        tbl[0] = {1'b1, 1'b0, L_YLW};
        tbl[1] = {1'b0, 1'b0, L_RED};
        tbl[2] = {1'b0, 1'b0, L_RED};
        tbl[3] = {1'b1, 1'b0, L_RED};
        tbl[4] = {1'b1, 1'b0, L_RED};
        tbl[5] = {1'b0, 1'b0, L_RED};
        for (int i = 0; i < 6; i++) begin
            drive_cycle(tbl[i][4], tbl[i][3], tbl[i][2:0]);
            exp = sb_q.pop_front();
            got = {red, ylw, grn};
            n_vectors++;
            if (got !== exp) begin
                $display("FAIL car_seq[%0d] got %b want %b", i, got, exp);
                n_miscompares++;
            end
        end
    endtask

    task automatic test_return();
        logic [4:0] tbl [3];
        logic [2:0] exp;
        logic [2:0] got;
        tbl[0] = {1'b0, 1'b1, L_GRN};
        tbl[1] = {1'b0, 1'b0, L_GRN};
        tbl[2] = {1'b0, 1'b1, L_GRN};
        for (int i = 0; i < 3; i++) begin
            drive_cycle(tbl[i][4], tbl[i][3], tbl[i][2:0]);
            exp = sb_q.pop_front();
            got = {red, ylw, grn};
            n_vectors++;
            if (got !== exp) begin
                $display("FAIL return[%0d] got %b want %b", i, got, exp);
                n_miscompares++;
            end
        end
    endtask

    // CAR and timeout both high: each state acts only on its own input.
    task automatic test_simultaneous();
        logic [4:0] tbl [5];
        logic [2:0] exp;
        logic [2:0] got;
        tbl[0] = {1'b1, 1'b1, L_YLW};
        tbl[1] = {1'b1, 1'b1, L_RED};
        tbl[2] = {1'b1, 1'b1, L_GRN};
        tbl[3] = {1'b1, 1'b1, L_YLW};
        tbl[4] = {1'b0, 1'b0, L_RED};
        for (int i = 0; i < 5; i++) begin
            drive_cycle(tbl[i][4], tbl[i][3], tbl[i][2:0]);
            exp = sb_q.pop_front();
            got = {red, ylw, grn};
            n_vectors++;
            if (got !== exp) begin
                $display("FAIL simultaneous[%0d] got %b want %b", i, got, exp);
                n_miscompares++;
            end
        end
        // Leave in GREEN for the next scenario.
        drive_cycle(1'b0, 1'b1, L_GRN);
        exp = sb_q.pop_front();
        got = {red, ylw, grn};
        n_vectors++;
        if (got !== exp) begin
            $display("FAIL simultaneous_exit got %b want %b", got, exp);
            n_miscompares++;
        end
    endtask

    // A CAR pulse that rises and falls between two edges must be missed.
    task automatic test_short_pulse();
        logic [2:0] exp;
        logic [2:0] got;
        @(negedge Clock);
        CAR     = 1'b0;
        timeout = 1'b0;
        @(posedge Clock);
        #2;
        CAR = 1'b1;
        #4;
        CAR = 1'b0;
        sb_q.push_back(L_GRN);
        @(posedge Clock);
        #1;
        exp = sb_q.pop_front();
        got = {red, ylw, grn};
        n_vectors++;
        if (got !== exp) begin
            $display("FAIL short_pulse got %b want %b", got, exp);
            n_miscompares++;
        end
    endtask

    task automatic test_async_reset();
        logic [2:0] exp;
        logic [2:0] got;
        // Into YELLOW, then reset between edges.
        drive_cycle(1'b1, 1'b0, L_YLW);
        exp = sb_q.pop_front();
        got = {red, ylw, grn};
        n_vectors++;
        if (got !== exp) begin
            $display("FAIL arst_pre_ylw got %b want %b", got, exp);
            n_miscompares++;
        end
        #1;
        Reset = 1'b0;
        sb_q.push_back(L_GRN);
        #1;
        exp = sb_q.pop_front();
        got = {red, ylw, grn};
        n_vectors++;
        if (got !== exp) begin
            $display("FAIL arst_in_ylw got %b want %b", got, exp);
            n_miscompares++;
        end
        @(negedge Clock);
        Reset = 1'b1;
        CAR   = 1'b0;
        // Into RED, then reset between edges.
        drive_cycle(1'b1, 1'b0, L_YLW);
        exp = sb_q.pop_front();
        got = {red, ylw, grn};
        n_vectors++;
        if (got !== exp) begin
            $display("FAIL arst_pre_ylw2 got %b want %b", got, exp);
            n_miscompares++;
        end
        drive_cycle(1'b0, 1'b0, L_RED);
        exp = sb_q.pop_front();
        got = {red, ylw, grn};
        n_vectors++;
        if (got !== exp) begin
            $display("FAIL arst_pre_red got %b want %b", got, exp);
            n_miscompares++;
        end
        #1;
        Reset = 1'b0;
        sb_q.push_back(L_GRN);
        #1;
        exp = sb_q.pop_front();
        got = {red, ylw, grn};
        n_vectors++;
        if (got !== exp) begin
            $display("FAIL arst_in_red got %b want %b", got, exp);
            n_miscompares++;
        end
        @(negedge Clock);
        Reset = 1'b1;
        // After release, stays GREEN with no car.
        drive_cycle(1'b0, 1'b0, L_GRN);
        exp = sb_q.pop_front();
        got = {red, ylw, grn};
        n_vectors++;
        if (got !== exp) begin
            $display("FAIL arst_release got %b want %b", got, exp);
            n_miscompares++;
        end
    endtask

    task automatic test_illegal();
        logic [2:0] exp;
        logic [2:0] got;
        @(negedge Clock);
        CAR     = 1'b1;
        timeout = 1'b0;
        force dut.u_s0.q = 1'b1;
        force dut.u_s1.q = 1'b1;
        #1;
        sb_q.push_back(L_OFF);
        exp = sb_q.pop_front();
        got = {red, ylw, grn};
        n_vectors++;
        if (got !== exp) begin
            $display("FAIL illegal_lamps got %b want %b", got, exp);
            n_miscompares++;
        end
        release dut.u_s0.q;
        release dut.u_s1.q;
        // CAR=1 is deliberately held: 2'b11 must go to GREEN regardless.
        sb_q.push_back(L_GRN);
        @(posedge Clock);
        #1;
        exp = sb_q.pop_front();
        got = {red, ylw, grn};
        n_vectors++;
        if (got !== exp) begin
            $display("FAIL illegal_recover got %b want %b", got, exp);
            n_miscompares++;
        end
        n_vectors++;
        if ({dut.u_s1.q, dut.u_s0.q} !== 2'b00) begin
            $display("FAIL illegal_state got %b want 00", {dut.u_s1.q, dut.u_s0.q});
            n_miscompares++;
        end
        @(negedge Clock);
        CAR = 1'b0;
    endtask

    initial begin
        n_vectors     = 0;
        n_miscompares = 0;
        onehot_en     = 1'b0;
        test_reset();
        test_idle();
        test_car_sequence();
        test_return();
        test_simultaneous();
        test_short_pulse();
        test_async_reset();
        test_illegal();
        n_vectors++;
        if (sb_q.size() != 0) begin
            $display("FAIL scoreboard_drain got %0d entries want 0", sb_q.size());
            n_miscompares++;
        end
        onehot_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
